// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and default timing constants
// for the staged reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RUN       = 3'd3,
    ST_GRACE     = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_NSTAGES       = 4;
  localparam int unsigned DEF_FILTER_CYCLES = 16;
  localparam int unsigned DEF_HOLD_CYCLES   = 64;
  localparam int unsigned DEF_DONE_TIMEOUT  = 1024;
  localparam int unsigned DEF_GRACE_CYCLES  = 256;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level
// into the clock_i domain.
module sync_2ff (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NSTAGES reset domains one at a time once the clocks
// and link are stable; re-sequences on link loss, timeout or soft reset.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NSTAGES       = DEF_NSTAGES,
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned DONE_TIMEOUT  = DEF_DONE_TIMEOUT,
  parameter int unsigned GRACE_CYCLES  = DEF_GRACE_CYCLES
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               mmcms_locked_i,
  input  logic               gbt_ready_i,
  input  logic               soft_reset_req_i,
  input  logic [NSTAGES-1:0] stage_done_i,
  output logic [NSTAGES-1:0] stage_reset_o,
  output logic               soft_reset_ack_o,
  output logic               ready_o,
  output logic               timeout_o,
  output logic [7:0]         reset_count_o,
  output logic [2:0]         state_o
);

  localparam int unsigned CMAX = max_u(
    max_u(FILTER_CYCLES, HOLD_CYCLES),
    max_u(DONE_TIMEOUT, GRACE_CYCLES));
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam int unsigned KW =
    (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  localparam logic [CW-1:0] C_FILT  = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO   = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] C_GRACE = CW'(GRACE_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(NSTAGES - 1);

  logic w_lock_s;
  logic w_gbt_s;
  logic w_link_ok;

  seq_state_e         r_state;
  logic [CW-1:0]      r_cnt;
  logic [KW-1:0]      r_k;
  logic [NSTAGES-1:0] r_rst;
  logic               r_ack;
  logic               r_ready;
  logic               r_timeout;
  logic [7:0]         r_count;

  seq_state_e         w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [KW-1:0]      w_k_nxt;
  logic [NSTAGES-1:0] w_rst_nxt;
  logic               w_ack_nxt;
  logic               w_ready_nxt;
  logic               w_timeout_nxt;
  logic [7:0]         w_count_nxt;
  logic               w_reseq;

  sync_2ff u_sync_lock (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .d_i       (mmcms_locked_i),
    .q_o       (w_lock_s)
  );

  sync_2ff u_sync_gbt (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .d_i       (gbt_ready_i),
    .q_o       (w_gbt_s)
  );

  assign w_link_ok = w_lock_s & w_gbt_s;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_k_nxt       = r_k;
    w_rst_nxt     = r_rst;
    w_ack_nxt     = 1'b0;
    w_timeout_nxt = r_timeout;
    w_count_nxt   = r_count;
    w_reseq       = 1'b0;

    unique case (r_state)
      ST_WAIT_LOCK: begin
        w_rst_nxt = '1;
        w_k_nxt   = '0;
        if (!w_link_ok) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == C_FILT) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (r_cnt == C_HOLD) begin
          w_rst_nxt[r_k] = 1'b0;
          w_state_nxt    = ST_WAIT_DONE;
          w_cnt_nxt      = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (stage_done_i[r_k]) begin
          w_cnt_nxt = '0;
          if (r_k == K_LAST) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_HOLD;
            w_k_nxt     = r_k + 1'b1;
          end
        end else if (r_cnt == C_TMO) begin
          w_timeout_nxt = 1'b1;
          w_reseq       = 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (soft_reset_req_i) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_GRACE;
        end
      end
      ST_GRACE: begin
        w_ack_nxt = soft_reset_req_i;
        if (r_cnt == C_GRACE) begin
          w_reseq = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase

    // Link loss overrides whatever the state decided this cycle.
    if (r_state != ST_WAIT_LOCK && !w_link_ok) begin
      w_reseq       = 1'b1;
      w_ack_nxt     = 1'b0;
      w_timeout_nxt = r_timeout;
    end

    if (w_reseq) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_k_nxt     = '0;
      w_rst_nxt   = '1;
      w_count_nxt = (r_count == 8'hFF) ? r_count
                                       : r_count + 8'd1;
    end

    w_ready_nxt = (w_state_nxt == ST_RUN) ||
                  (w_state_nxt == ST_GRACE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= '0;
      r_k       <= '0;
      r_rst     <= '1;
      r_ack     <= 1'b0;
      r_ready   <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_k       <= w_k_nxt;
      r_rst     <= w_rst_nxt;
      r_ack     <= w_ack_nxt;
      r_ready   <= w_ready_nxt;
      r_timeout <= w_timeout_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign stage_reset_o    = r_rst;
  assign soft_reset_ack_o = r_ack;
  assign ready_o          = r_ready;
  assign timeout_o        = r_timeout;
  assign reset_count_o    = r_count;
  assign state_o          = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: spec-derived vector table, directed
// corner sequences and random stimulus against a reference model.
module tb_reset_sequencer;

  localparam int NST   = 4;
  localparam int FILT  = 16;
  localparam int HOLD  = 64;
  localparam int TMO   = 1024;
  localparam int GRACE = 256;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       lock  = 1'b0;
  logic       gbt   = 1'b0;
  logic       req   = 1'b0;
  logic [3:0] done  = 4'h0;
  logic [3:0] srst;
  logic       ack;
  logic       rdy;
  logic       tmo;
  logic [7:0] rcnt;
  logic [2:0] st;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .mmcms_locked_i   (lock),
    .gbt_ready_i      (gbt),
    .soft_reset_req_i (req),
    .stage_done_i     (done),
    .stage_reset_o    (srst),
    .soft_reset_ack_o (ack),
    .ready_o          (rdy),
    .timeout_o        (tmo),
    .reset_count_o    (rcnt),
    .state_o          (st)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase numbers are the spec's state values,
  // phase expiry is tracked as an absolute deadline cycle.
  int m_phase;
  int m_nrel;
  int m_okrun;
  int m_count;
  int m_cyc;
  int m_deadline;
  bit m_ack;
  bit m_timeout;
  bit link_q[$];

  task automatic model_reset();
    m_phase = 0; m_nrel = 0; m_okrun = 0; m_count = 0;
    m_cyc = 0; m_deadline = 0; m_ack = 0; m_timeout = 0;
    link_q.delete();
    link_q.push_back(1'b0);
    link_q.push_back(1'b0);
  endtask

  task automatic goto_lock();
    m_phase = 0;
    m_okrun = 0;
    m_nrel  = 0;
    if (m_count < 255) m_count++;
  endtask

  task automatic model_step(input logic l, input logic g,
                            input logic q, input logic [3:0] d);
    bit lk;
    m_cyc++;
    link_q.push_back(l & g);
    lk = link_q.pop_front();
    m_ack = 0;
    if (m_phase != 0 && !lk) begin
      goto_lock();
    end else begin
      case (m_phase)
        0: begin
          m_nrel = 0;
          if (!lk) m_okrun = 0;
          else begin
            m_okrun++;
            if (m_okrun == FILT) begin
              m_phase = 1;
              m_deadline = m_cyc + HOLD;
            end
          end
        end
        1: if (m_cyc == m_deadline) begin
          m_nrel++;
          m_phase = 2;
          m_deadline = m_cyc + TMO;
        end
        2: if (d[m_nrel-1]) begin
          if (m_nrel == NST) m_phase = 3;
          else begin
            m_phase = 1;
            m_deadline = m_cyc + HOLD;
          end
        end else if (m_cyc == m_deadline) begin
          m_timeout = 1;
          goto_lock();
        end
        3: if (q) begin
          m_ack = 1;
          m_phase = 4;
          m_deadline = m_cyc + GRACE;
        end
        4: begin
          m_ack = q;
          if (m_cyc == m_deadline) goto_lock();
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic logic [17:0] bus(input int s, input int rs,
    input int r, input int a, input int t, input int c);
    return {s[2:0], rs[3:0], r[0], a[0], t[0], c[7:0]};
  endfunction

  function automatic logic [17:0] dut_bus();
    return {st, srst, rdy, ack, tmo, rcnt};
  endfunction

  function automatic logic [17:0] model_bus();
    int rs;
    int r;
    rs = 0;
    for (int i = 0; i < NST; i++)
      if (i >= m_nrel) rs = rs | (1 << i);
    r = (m_phase == 3 || m_phase == 4) ? 1 : 0;
    return bus(m_phase, rs, r, int'(m_ack),
               int'(m_timeout), m_count);
  endfunction

  task automatic check(input string name,
                       input logic [17:0] got,
                       input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h",
               name, m_cyc, got, exp);
    end
  endtask

  task automatic tick();
    logic l, g, q, r;
    logic [3:0] d;
    l = lock; g = gbt; q = req; d = done; r = rst_n;
    @(posedge clk);
    #1;
    if (!r) model_reset();
    else model_step(l, g, q, d);
    check("model", dut_bus(), model_bus());
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check("async_reset", dut_bus(), bus(0, 15, 0, 0, 0, 0));
    tick_n(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int i = 0; i < budget && int'(st) != s; i++) tick();
    n_vec++;
    if (int'(st) != s) begin
      n_err++;
      $display("FAIL wait_state got=%0d expected=%0d", st, s);
    end
  endtask

  task automatic reach_run();
    lock = 1; gbt = 1; req = 0; done = 4'hF;
    apply_reset();
    wait_state(3, 400);
  endtask

  typedef struct {
    int         ncyc;
    logic       l, g, q;
    logic [3:0] d;
    logic [17:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  function automatic vec_t mk(input int n, input int q,
    input int d, input int s, input int rs, input int r,
    input int a, input int c);
    vec_t v;
    v.ncyc = n;
    v.l = 1'b1;
    v.g = 1'b1;
    v.q = q[0];
    v.d = d[3:0];
    v.exp = bus(s, rs, r, a, 0, c);
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Start-up from reset; cumulative cycle noted per row.
    tbl[0]  = mk(17,  0, 4'h0, 0, 15, 0, 0, 0); // 17
    tbl[1]  = mk(1,   0, 4'h0, 1, 15, 0, 0, 0); // 18
    tbl[2]  = mk(63,  0, 4'h0, 1, 15, 0, 0, 0); // 81
    tbl[3]  = mk(1,   0, 4'h0, 2, 14, 0, 0, 0); // 82
    tbl[4]  = mk(5,   0, 4'h0, 2, 14, 0, 0, 0); // 87
    tbl[5]  = mk(1,   0, 4'h1, 1, 14, 0, 0, 0); // 88
    tbl[6]  = mk(64,  0, 4'h1, 2, 12, 0, 0, 0); // 152
    tbl[7]  = mk(1,   0, 4'h3, 1, 12, 0, 0, 0); // 153
    tbl[8]  = mk(64,  0, 4'h3, 2, 8,  0, 0, 0); // 217
    tbl[9]  = mk(1,   0, 4'h7, 1, 8,  0, 0, 0); // 218
    tbl[10] = mk(64,  0, 4'h7, 2, 0,  0, 0, 0); // 282
    tbl[11] = mk(3,   0, 4'h7, 2, 0,  0, 0, 0); // 285
    tbl[12] = mk(1,   0, 4'hF, 3, 0,  1, 0, 0); // 286
    tbl[13] = mk(1,   1, 4'hF, 4, 0,  1, 1, 0); // 287
    tbl[14] = mk(1,   0, 4'hF, 4, 0,  1, 0, 0); // 288
    tbl[15] = mk(1,   1, 4'hF, 4, 0,  1, 1, 0); // 289
    tbl[16] = mk(253, 0, 4'hF, 4, 0,  1, 0, 0); // 542
    tbl[17] = mk(1,   0, 4'hF, 0, 15, 0, 0, 1); // 543
    tbl[18] = mk(15,  0, 4'hF, 0, 15, 0, 0, 1); // 558
    tbl[19] = mk(1,   0, 4'hF, 1, 15, 0, 0, 1); // 559
    tbl[20] = mk(1,   1, 4'hF, 1, 15, 0, 0, 1); // 560

    #1;
    lock = 1; gbt = 1; req = 0; done = 4'h0;
    apply_reset();
    for (int i = 0; i < NV; i++) begin
      lock = tbl[i].l;
      gbt  = tbl[i].g;
      req  = tbl[i].q;
      done = tbl[i].d;
      for (int j = 0; j < tbl[i].ncyc; j++) begin
        tick();
        req = 1'b0;
      end
      check($sformatf("vec%0d", i), dut_bus(), tbl[i].exp);
    end

    // One-cycle lock glitch while the filter is at 10.
    lock = 1; gbt = 1; req = 0; done = 4'h0;
    apply_reset();
    tick_n(10);
    lock = 0;
    tick();
    lock = 1;
    tick_n(17);
    check("glitch_c28", dut_bus(), bus(0, 15, 0, 0, 0, 0));
    tick();
    check("glitch_c29", dut_bus(), bus(1, 15, 0, 0, 0, 0));

    // gbt drop while running.
    reach_run();
    gbt = 0;
    tick_n(2);
    check("drop_c2", dut_bus(), bus(3, 0, 1, 0, 0, 0));
    tick();
    check("drop_c3", dut_bus(), bus(0, 15, 0, 0, 0, 1));
    gbt = 1;

    // Soft request and link loss on the same cycle.
    reach_run();
    gbt = 0;
    tick_n(2);
    req = 1;
    tick();
    req = 0;
    check("soft_and_drop", dut_bus(), bus(0, 15, 0, 0, 0, 1));
    gbt = 1;
    tick();
    check("soft_drop_noack", dut_bus(), bus(0, 15, 0, 0, 0, 1));

    // Stage 2 never reports done.
    lock = 1; gbt = 1; req = 0; done = 4'b1011;
    apply_reset();
    tick_n(2 + FILT + 3 * HOLD + 2);
    check("wd2_entry", dut_bus(), bus(2, 8, 0, 0, 0, 0));
    tick_n(TMO - 1);
    check("wd2_before", dut_bus(), bus(2, 8, 0, 0, 0, 0));
    tick();
    check("wd2_timeout", dut_bus(), bus(0, 15, 0, 0, 1, 1));
    tick_n(20);
    check("tmo_sticky", dut_bus(), bus(1, 15, 0, 0, 1, 1));

    // Reset mid-sequence clears everything and restarts.
    apply_reset();
    tick_n(81);
    check("restart_c81", dut_bus(), bus(1, 15, 0, 0, 0, 0));
    tick();
    check("restart_c82", dut_bus(), bus(2, 14, 0, 0, 0, 0));

    // reset_count_o saturation.
    lock = 1; gbt = 1; req = 0; done = 4'h0;
    apply_reset();
    for (int i = 0; i < 258; i++) begin
      wait_state(1, 60);
      lock = 0;
      tick();
      lock = 1;
      wait_state(0, 10);
    end
    wait_state(1, 60);
    check("count_sat", dut_bus(), bus(1, 15, 0, 0, 0, 255));

    // Random stimulus against the model.
    lock = 1; gbt = 1; req = 0; done = 4'hF;
    apply_reset();
    for (int i = 0; i < 15000; i++) begin
      lock = ($urandom_range(0, 2999) != 0);
      gbt  = ($urandom_range(0, 2999) != 0);
      req  = ($urandom_range(0, 39) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 199) == 0) done[b] = ~done[b];
      if ($urandom_range(0, 4999) == 0) apply_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
